// File: rtl/write_back_stage.sv
// Write-back stage: selects ALU or memory data, formats loads (byte/half/word),
// flags misaligned loads and registers the register-file write for one cycle.
module write_back_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] alu_result,
  input  logic signed [31:0] mem_data,
  input  logic               load_data_sel,
  output logic signed [31:0] wb_data,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rd_addr_in,
  input  logic               reg_write_in,
  input  logic               valid_in,
  output logic [31:0]        rd_wdata,
  output logic [4:0]         rd_addr_out,
  output logic               reg_write_out,
  output logic               valid_out,
  output logic               misaligned
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [31:0] fmt;
  logic        mis_align;

  logic [31:0] rd_wdata_q, rd_wdata_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        reg_write_q, reg_write_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  assign wb_data = load_data_sel ? mem_data : alu_result;

  always_comb begin
    off      = alu_result[1:0];
    byte_sel = mem_data[7:0];
    case (off)
      2'd0: byte_sel = mem_data[7:0];
      2'd1: byte_sel = mem_data[15:8];
      2'd2: byte_sel = mem_data[23:16];
      2'd3: byte_sel = mem_data[31:24];
      default: byte_sel = mem_data[7:0];
    endcase
    // Halfword is picked by off[1] only; a set off[0] is reported as misaligned.
    half_sel = off[1] ? mem_data[31:16] : mem_data[15:0];

    load_fmt = mem_data;
    case (funct3)
      F3_LB:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_fmt = {24'd0, byte_sel};
      F3_LH:   load_fmt = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_fmt = {16'd0, half_sel};
      default: load_fmt = mem_data;
    endcase

    mis_align = 1'b0;
    if (load_data_sel) begin
      case (funct3)
        F3_LH, F3_LHU: mis_align = off[0];
        F3_LW:         mis_align = (off != 2'd0);
        default:       mis_align = 1'b0;
      endcase
    end

    fmt = load_data_sel ? load_fmt : alu_result;
  end

  // No handshake: a new instruction is accepted every cycle and appears on the
  // registered outputs exactly one cycle later; valid_out qualifies it.
  always_comb begin
    rd_wdata_d  = fmt;
    rd_addr_d   = rd_addr_in;
    valid_d     = valid_in;
    mis_d       = valid_in & mis_align;
    reg_write_d = valid_in & reg_write_in & (rd_addr_in != 5'd0) & ~mis_align;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wdata_q  <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      rd_wdata_q  <= rd_wdata_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
    end
  end

  assign rd_wdata      = rd_wdata_q;
  assign rd_addr_out   = rd_addr_q;
  assign reg_write_out = reg_write_q;
  assign valid_out     = valid_q;
  assign misaligned    = mis_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed load-format vectors, randomized
// back-to-back traffic against a behavioural model, and mid-stream reset.
module tb_write_back_stage;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] alu_result;
  logic signed [31:0] mem_data;
  logic               load_data_sel;
  logic signed [31:0] wb_data;
  logic [2:0]         funct3;
  logic [4:0]         rd_addr_in;
  logic               reg_write_in;
  logic               valid_in;
  logic [31:0]        rd_wdata;
  logic [4:0]         rd_addr_out;
  logic               reg_write_out;
  logic               valid_out;
  logic               misaligned;

  int pass_cnt  = 0;
  int total_cnt = 0;

  write_back_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_result    (alu_result),
    .mem_data      (mem_data),
    .load_data_sel (load_data_sel),
    .wb_data       (wb_data),
    .funct3        (funct3),
    .rd_addr_in    (rd_addr_in),
    .reg_write_in  (reg_write_in),
    .valid_in      (valid_in),
    .rd_wdata      (rd_wdata),
    .rd_addr_out   (rd_addr_out),
    .reg_write_out (reg_write_out),
    .valid_out     (valid_out),
    .misaligned    (misaligned)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_fmt(input logic sel, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [2:0] f3);
    int unsigned off, b, h;
    off = alu % 4;
    b = (mem / (1 << (8 * off))) % 256;
    h = (mem / (1 << (16 * (off / 2)))) % 65536;
    if (!sel) return alu;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return mem;
    endcase
  endfunction

  function automatic logic model_mis(input logic sel, input logic [31:0] alu, input logic [2:0] f3);
    int unsigned off;
    off = alu % 4;
    if (!sel) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic sel, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [2:0] f3, input logic [4:0] rd, input logic rw, input logic vin);
    load_data_sel = sel;
    alu_result    = alu;
    mem_data      = mem;
    funct3        = f3;
    rd_addr_in    = rd;
    reg_write_in  = rw;
    valid_in      = vin;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic        vin;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 3'd2, 5'd5, 1'b1, 1'b1);
    #3;
    total_cnt++;
    if ({rd_wdata, rd_addr_out, reg_write_out, valid_out, misaligned} !== 40'd0)
      $display("FAIL reset_outputs: got %h/%h/%b/%b/%b want all zero",
               rd_wdata, rd_addr_out, reg_write_out, valid_out, misaligned);
    else pass_cnt++;
    total_cnt++;
    if (wb_data !== 32'h0000_0010) $display("FAIL reset_wb_alu: got %h want 00000010", wb_data);
    else pass_cnt++;
    load_data_sel = 1'b1;
    #2;
    total_cnt++;
    if (wb_data !== 32'hDEAD_BEEF) $display("FAIL reset_wb_mem: got %h want deadbeef", wb_data);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({rd_wdata, reg_write_out, valid_out} !== 34'd0)
      $display("FAIL reset_held_across_edge: got %h/%b/%b want zero", rd_wdata, reg_write_out, valid_out);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_format();
    vec_t v[$];
    v.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, 5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h0,  32'h8000_FF7F, 3'd0, 5'd3, 1'b1, 1'b1, 32'h0000_007F, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h1,  32'h8000_FF7F, 3'd0, 5'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h3,  32'h8000_FF7F, 3'd4, 5'd4, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h0,  32'h8000_FF7F, 3'd1, 5'd6, 1'b1, 1'b1, 32'hFFFF_FF7F, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h2,  32'h8000_FF7F, 3'd1, 5'd6, 1'b1, 1'b1, 32'hFFFF_8000, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h1,  32'h8000_FF7F, 3'd1, 5'd6, 1'b1, 1'b1, 32'hFFFF_FF7F, 1'b0, 1'b1});
    v.push_back('{1'b1, 32'h2,  32'h8000_FF7F, 3'd2, 5'd7, 1'b1, 1'b1, 32'h8000_FF7F, 1'b0, 1'b1});
    v.push_back('{1'b1, 32'h2,  32'h8000_FF7F, 3'd5, 5'd8, 1'b1, 1'b1, 32'h0000_8000, 1'b1, 1'b0});
    v.push_back('{1'b1, 32'h1,  32'h8000_FF7F, 3'd7, 5'd8, 1'b1, 1'b1, 32'h8000_FF7F, 1'b1, 1'b0});
    v.push_back('{1'b0, 32'h1,  32'h8000_FF7F, 3'd1, 5'd9, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0});
    foreach (v[i]) begin
      drive(v[i].sel, v[i].alu, v[i].mem, v[i].f3, v[i].rd, v[i].rw, v[i].vin);
      #1;
      total_cnt++;
      if (wb_data !== (v[i].sel ? v[i].mem : v[i].alu))
        $display("FAIL fmt%0d_wb_data: got %h want %h", i, wb_data, v[i].sel ? v[i].mem : v[i].alu);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (rd_wdata !== v[i].exp_wdata)
        $display("FAIL fmt%0d_rd_wdata: got %h want %h", i, rd_wdata, v[i].exp_wdata);
      else pass_cnt++;
      total_cnt++;
      if ({rd_addr_out, reg_write_out, misaligned, valid_out} !== {v[i].rd, v[i].exp_we, v[i].exp_mis, 1'b1})
        $display("FAIL fmt%0d_ctrl: got rd=%0d we=%b mis=%b vld=%b want rd=%0d we=%b mis=%b vld=1",
                 i, rd_addr_out, reg_write_out, misaligned, valid_out, v[i].rd, v[i].exp_we, v[i].exp_mis);
      else pass_cnt++;
    end
  endtask

  task automatic test_x0_and_invalid();
    drive(1'b0, 32'h0000_ABCD, 32'h0, 3'd2, 5'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    total_cnt++;
    if ({rd_wdata, reg_write_out, valid_out} !== {32'h0000_ABCD, 1'b0, 1'b1})
      $display("FAIL x0_suppress: got wdata=%h we=%b vld=%b want 0000abcd/0/1", rd_wdata, reg_write_out, valid_out);
    else pass_cnt++;
    drive(1'b1, 32'h1, 32'h8000_FF7F, 3'd1, 5'd9, 1'b1, 1'b0);
    @(posedge clk); #1;
    total_cnt++;
    if ({rd_wdata, rd_addr_out, reg_write_out, misaligned, valid_out} !== {32'hFFFF_FF7F, 5'd9, 3'b000})
      $display("FAIL invalid_slot: got wdata=%h rd=%0d we=%b mis=%b vld=%b want ffffff7f/9/0/0/0",
               rd_wdata, rd_addr_out, reg_write_out, misaligned, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] exp_q[$];
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    logic        e_we, e_mis, e_vld, sel, rw, vin, mis;
    logic [31:0] alu, mem;
    logic [2:0]  f3;
    logic [4:0]  rd;
    for (int n = 0; n < 300; n++) begin
      sel = 1'($urandom_range(0, 1));
      alu = $urandom;
      mem = $urandom;
      f3  = 3'($urandom_range(0, 7));
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rw  = 1'($urandom_range(0, 3) != 0);
      vin = 1'($urandom_range(0, 4) != 0);
      drive(sel, alu, mem, f3, rd, rw, vin);
      mis = model_mis(sel, alu, f3);
      exp_q.push_back(model_fmt(sel, alu, mem, f3));
      e_rd  = rd;
      e_vld = vin;
      e_mis = vin && mis;
      e_we  = vin && rw && (rd != 0) && !mis;
      #1;
      total_cnt++;
      if (wb_data !== (sel ? mem : alu))
        $display("FAIL rand%0d_wb_data: got %h want %h", n, wb_data, sel ? mem : alu);
      else pass_cnt++;
      @(posedge clk); #1;
      e_wdata = exp_q.pop_front();
      total_cnt++;
      if ({rd_wdata, rd_addr_out, reg_write_out, misaligned, valid_out} !== {e_wdata, e_rd, e_we, e_mis, e_vld})
        $display("FAIL rand%0d_regs: got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b (f3=%0d off=%0d sel=%b)",
                 n, rd_wdata, rd_addr_out, reg_write_out, misaligned, valid_out,
                 e_wdata, e_rd, e_we, e_mis, e_vld, f3, alu[1:0], sel);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h0, 32'h1234_5678, 3'd2, 5'd11, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rd_wdata, rd_addr_out, reg_write_out, valid_out, misaligned} !== 40'd0)
      $display("FAIL midreset_async_clear: got %h/%h/%b/%b/%b want all zero",
               rd_wdata, rd_addr_out, reg_write_out, valid_out, misaligned);
    else pass_cnt++;
    mem_data = 32'h0BAD_F00D;
    #1;
    total_cnt++;
    if (wb_data !== 32'h0BAD_F00D) $display("FAIL midreset_wb_tracks: got %h want 0badf00d", wb_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h2, 32'hCAFE_0123, 3'd4, 5'd12, 1'b1, 1'b1);
    @(posedge clk); #1;
    total_cnt++;
    if ({rd_wdata, rd_addr_out, reg_write_out, valid_out} !== {32'h0000_00FE, 5'd12, 2'b11})
      $display("FAIL midreset_resume: got %h/%0d/%b/%b want 000000fe/12/1/1",
               rd_wdata, rd_addr_out, reg_write_out, valid_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_x0_and_invalid();
    test_back_to_back_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
